// File: rtl/branch_pkg.sv
// branch_pkg
//   Shared types for the branch resolve unit:
//   - funct3_e     : branch condition encodings
//   - bht_ctr_e    : 2-bit saturating predictor counter (SNT/WNT/WT/ST)
//   - BHT_RESET    : counter value loaded into every BHT entry on reset
//   - bht_ctr_next : saturating counter update
package branch_pkg;

  typedef enum logic [2:0] {
    F3_EQ  = 3'b000,
    F3_NE  = 3'b001,
    F3_LT  = 3'b100,
    F3_GE  = 3'b101,
    F3_LTU = 3'b110,
    F3_GEU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  localparam bht_ctr_e BHT_RESET = WNT;

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic bht_ctr_e bht_ctr_next(input bht_ctr_e ctr, input logic taken);
    bht_ctr_e nxt;
    nxt = ctr;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// branch_history_table
//   Table of 2-bit saturating predictors.
//   clk      : clock, rising edge
//   rstB     : synchronous active-low reset, every entry -> BHT_RESET
//   rd_idx   : lookup index (asynchronous read)
//   rd_taken : MSB of the addressed counter
//   wr_en    : apply one outcome to entry wr_idx at the next edge
//   wr_idx   : update index
//   wr_taken : resolved direction to fold into the counter
// The write port performs the read-modify-write internally, so a same-index
// lookup in the update cycle still sees the old counter.
module branch_history_table
  import branch_pkg::*;
#(
  parameter  int BHT_DEPTH = 16,
  localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rstB,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_e table_r [BHT_DEPTH];

  // Counter storage: reset to weakly not-taken, otherwise saturating update.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        table_r[i] <= BHT_RESET;
      end
    end else if (wr_en) begin
      table_r[wr_idx] <= bht_ctr_next(table_r[wr_idx], wr_taken);
    end
  end

  assign rd_taken = table_r[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves the branch/jump in execute, drives the fetch redirect and keeps
//   a 2-bit branch history table for fetch-side prediction.
//   clk, rstB                       : clock, synchronous active-low reset
//   ex_valid                        : executing instruction valid
//   b_type / op_jal / op_jalr       : instruction class
//   imm21_j / imm12_i_s / imm13_b   : raw immediates
//   funct3                          : branch condition
//   sub_result/sub_sign/sub_borrow  : rs1-rs2 result and less-than flags
//   pc_current                      : fetch PC (branch PC + PIPE_OFFSET)
//   link_reg_in                     : rs1 for JALR
//   ex_pred_taken                   : prediction travelling with the branch
//   fetch_pc / predict_taken        : BHT lookup
//   pc_return                       : link value for live JAL/JALR, else 0
//   pc_jmpto                        : redirect target or fall-through
//   jmp_occur                       : redirect or flush in progress
//   mispredict                      : live conditional branch mispredicted
//   target_misaligned               : redirect target has bit 1 set
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_DEPTH    = 16,
  parameter int PIPE_OFFSET  = 8,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic            ex_valid,
  input  logic            b_type,
  input  logic            op_jal,
  input  logic            op_jalr,
  input  logic [20:0]     imm21_j,
  input  logic [11:0]     imm12_i_s,
  input  logic [12:0]     imm13_b,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] sub_result,
  input  logic            sub_sign,
  input  logic            sub_borrow,
  input  logic [XLEN-1:0] pc_current,
  input  logic [XLEN-1:0] link_reg_in,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] pc_return,
  output logic [XLEN-1:0] pc_jmpto,
  output logic            jmp_occur,
  output logic            mispredict,
  output logic            target_misaligned
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [2:0]      flush_cnt_r;
  logic [2:0]      cnt_eff_s;
  logic [XLEN-1:0] bpc_s;
  logic [XLEN-1:0] ft_s;
  logic [XLEN-1:0] jal_tgt_s;
  logic [XLEN-1:0] br_tgt_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] jalr_tgt_s;
  logic [XLEN-1:0] jmpto_s;
  logic            taken_s;
  logic            live_s;
  logic            br_mis_s;
  logic            redirect_s;
  logic            unused_s;

  // While reset is held the flush state is considered already cleared.
  assign cnt_eff_s = rstB ? flush_cnt_r : 3'd0;
  assign live_s    = ex_valid && (cnt_eff_s == 3'd0);

  assign bpc_s      = pc_current - XLEN'(PIPE_OFFSET);
  assign ft_s       = bpc_s + XLEN'(32'd4);
  assign jal_tgt_s  = bpc_s + {{(XLEN-21){imm21_j[20]}}, imm21_j};
  assign br_tgt_s   = bpc_s + {{(XLEN-13){imm13_b[12]}}, imm13_b};
  assign jalr_sum_s = link_reg_in + {{(XLEN-12){imm12_i_s[11]}}, imm12_i_s};
  assign jalr_tgt_s = {jalr_sum_s[XLEN-1:1], 1'b0};

  // Branch condition evaluation from the subtractor flags.
  always_comb begin
    taken_s = 1'b0;
    case (funct3)
      F3_EQ:   taken_s = (sub_result == {XLEN{1'b0}});
      F3_NE:   taken_s = (sub_result != {XLEN{1'b0}});
      F3_LT:   taken_s = sub_sign;
      F3_GE:   taken_s = !sub_sign;
      F3_LTU:  taken_s = sub_borrow;
      F3_GEU:  taken_s = !sub_borrow;
      default: taken_s = 1'b0;
    endcase
  end

  assign br_mis_s   = live_s && b_type && (taken_s != ex_pred_taken);
  assign redirect_s = (live_s && (op_jal || op_jalr)) || br_mis_s;

  // Target selection; shadow or invalid slots fall through.
  always_comb begin
    jmpto_s = ft_s;
    if (live_s && op_jal) begin
      jmpto_s = jal_tgt_s;
    end else if (live_s && op_jalr) begin
      jmpto_s = jalr_tgt_s;
    end else if (live_s && b_type && taken_s) begin
      jmpto_s = br_tgt_s;
    end else begin
      jmpto_s = ft_s;
    end
  end

  // Flush counter: load on redirect, drain to zero, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      flush_cnt_r <= 3'd0;
    end else if (redirect_s) begin
      flush_cnt_r <= 3'(FLUSH_CYCLES);
    end else if (flush_cnt_r != 3'd0) begin
      flush_cnt_r <= flush_cnt_r - 3'd1;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  assign pc_jmpto          = jmpto_s;
  assign pc_return         = (live_s && (op_jal || op_jalr)) ? ft_s : {XLEN{1'b0}};
  assign jmp_occur         = redirect_s || (cnt_eff_s != 3'd0);
  assign mispredict        = br_mis_s;
  assign target_misaligned = redirect_s && jmpto_s[1];

  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk      (clk),
    .rstB     (rstB),
    .rd_idx   (fetch_pc[IDX_W+1:2]),
    .rd_taken (predict_taken),
    .wr_en    (live_s && b_type),
    .wr_idx   (bpc_s[IDX_W+1:2]),
    .wr_taken (taken_s)
  );

  // PC bits outside the table index and the dropped JALR LSB carry no state.
  assign unused_s = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                      bpc_s[XLEN-1:IDX_W+2], bpc_s[1:0], jalr_sum_s[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//   Directed vectors for branch_resolve_unit (XLEN=32, BHT_DEPTH=16,
//   PIPE_OFFSET=8, FLUSH_CYCLES=3) with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rstB;
  logic        ex_valid;
  logic        b_type;
  logic        op_jal;
  logic        op_jalr;
  logic [20:0] imm21_j;
  logic [11:0] imm12_i_s;
  logic [12:0] imm13_b;
  logic [2:0]  funct3;
  logic [31:0] sub_result;
  logic        sub_sign;
  logic        sub_borrow;
  logic [31:0] pc_current;
  logic [31:0] link_reg_in;
  logic        ex_pred_taken;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] pc_return;
  logic [31:0] pc_jmpto;
  logic        jmp_occur;
  logic        mispredict;
  logic        target_misaligned;

  int checks_total;
  int checks_passed;

  branch_resolve_unit #(
    .XLEN         (32),
    .BHT_DEPTH    (16),
    .PIPE_OFFSET  (8),
    .FLUSH_CYCLES (3)
  ) dut (
    .clk               (clk),
    .rstB              (rstB),
    .ex_valid          (ex_valid),
    .b_type            (b_type),
    .op_jal            (op_jal),
    .op_jalr           (op_jalr),
    .imm21_j           (imm21_j),
    .imm12_i_s         (imm12_i_s),
    .imm13_b           (imm13_b),
    .funct3            (funct3),
    .sub_result        (sub_result),
    .sub_sign          (sub_sign),
    .sub_borrow        (sub_borrow),
    .pc_current        (pc_current),
    .link_reg_in       (link_reg_in),
    .ex_pred_taken     (ex_pred_taken),
    .fetch_pc          (fetch_pc),
    .predict_taken     (predict_taken),
    .pc_return         (pc_return),
    .pc_jmpto          (pc_jmpto),
    .jmp_occur         (jmp_occur),
    .mispredict        (mispredict),
    .target_misaligned (target_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    b_type        = 1'b0;
    op_jal        = 1'b0;
    op_jalr       = 1'b0;
    imm21_j       = 21'd0;
    imm12_i_s     = 12'd0;
    imm13_b       = 13'd0;
    funct3        = 3'd0;
    sub_result    = 32'd0;
    sub_sign      = 1'b0;
    sub_borrow    = 1'b0;
    link_reg_in   = 32'd0;
    ex_pred_taken = 1'b0;
  endtask

  task automatic drive_jal(input logic [31:0] pc, input logic [20:0] imm);
    idle();
    ex_valid   = 1'b1;
    op_jal     = 1'b1;
    pc_current = pc;
    imm21_j    = imm;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] res,
                          input logic sgn, input logic brw, input logic pred, input logic [12:0] imm);
    idle();
    ex_valid      = 1'b1;
    b_type        = 1'b1;
    pc_current    = pc;
    funct3        = f3;
    sub_result    = res;
    sub_sign      = sgn;
    sub_borrow    = brw;
    ex_pred_taken = pred;
    imm13_b       = imm;
  endtask

  // Leave the redirect cycle, idle through FLUSH_CYCLES, expect the flush over.
  task automatic drain(input string tag);
    tick();
    idle();
    tick();
    tick();
    tick();
    chk(tag, {31'd0, jmp_occur}, 32'd0);
  endtask

  // condition table: funct3, sub_result, sign, borrow, expected taken
  logic [2:0]  tv_f3  [9] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
  logic [31:0] tv_res [9] = '{32'd0, 32'd5, 32'd5, 32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0};
  logic        tv_sgn [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        tv_brw [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        tv_tkn [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    idle();
    pc_current = 32'd0;
    fetch_pc   = 32'd0;
    rstB       = 1'b0;
    tick();
    tick();
    chk("rst_jmp_during", {31'd0, jmp_occur}, 32'd0);
    rstB = 1'b1;
    tick();
    chk("rst_jmp", {31'd0, jmp_occur}, 32'd0);
    chk("rst_pred", {31'd0, predict_taken}, 32'd0);
    chk("rst_ret", pc_return, 32'd0);
    chk("rst_mis", {31'd0, mispredict}, 32'd0);

    // JAL: bpc 0x100, target 0x120, link 0x104; then JALs in the shadow
    drive_jal(32'h108, 21'h20);
    #1;
    chk("jal_tgt", pc_jmpto, 32'h120);
    chk("jal_ret", pc_return, 32'h104);
    chk("jal_jmp", {31'd0, jmp_occur}, 32'd1);
    chk("jal_misal", {31'd0, target_misaligned}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive_jal(32'h108, 21'h40);
      #1;
      chk("shadow_jmp", {31'd0, jmp_occur}, 32'd1);
      chk("shadow_ret", pc_return, 32'd0);
    end
    tick();
    idle();
    #1;
    chk("flush_end", {31'd0, jmp_occur}, 32'd0);

    // JALR 0x203 + 0 -> 0x202, misaligned but still redirects
    idle();
    ex_valid    = 1'b1;
    op_jalr     = 1'b1;
    pc_current  = 32'h108;
    link_reg_in = 32'h203;
    #1;
    chk("jalr_tgt", pc_jmpto, 32'h202);
    chk("jalr_misal", {31'd0, target_misaligned}, 32'd1);
    chk("jalr_jmp", {31'd0, jmp_occur}, 32'd1);
    chk("jalr_ret", pc_return, 32'h104);
    drain("jalr_drain");

    // BLTU taken, predicted not-taken: bpc 0x200, imm -8 -> 0x1F8
    drive_br(32'h208, 3'b110, 32'd3, 1'b0, 1'b1, 1'b0, 13'h1FF8);
    #1;
    chk("bltu_mis", {31'd0, mispredict}, 32'd1);
    chk("bltu_jmp", {31'd0, jmp_occur}, 32'd1);
    chk("bltu_tgt", pc_jmpto, 32'h1F8);
    chk("bltu_ret", pc_return, 32'd0);
    drain("bltu_drain");
    // BLT with the same operands: not taken, agrees with prediction
    drive_br(32'h208, 3'b100, 32'd3, 1'b0, 1'b1, 1'b0, 13'h1FF8);
    #1;
    chk("blt_mis", {31'd0, mispredict}, 32'd0);
    chk("blt_jmp", {31'd0, jmp_occur}, 32'd0);
    chk("blt_tgt", pc_jmpto, 32'h204);
    tick();

    // Condition table, prediction always correct: bpc 0x300, target 0x340
    for (int i = 0; i < 9; i++) begin
      drive_br(32'h308, tv_f3[i], tv_res[i], tv_sgn[i], tv_brw[i], tv_tkn[i], 13'h40);
      #1;
      chk("cond_mis", {31'd0, mispredict}, 32'd0);
      chk("cond_tgt", pc_jmpto, tv_tkn[i] ? 32'h340 : 32'h304);
      tick();
    end

    // BHT training at index 5 (bpc 0x114), lookup at the same index
    fetch_pc = 32'h114;
    drive_br(32'h11C, 3'b000, 32'd0, 1'b0, 1'b0, 1'b1, 13'h10);
    #1;
    chk("bht_pred0_same_cycle", {31'd0, predict_taken}, 32'd0);
    chk("bht_t1_mis", {31'd0, mispredict}, 32'd0);
    tick();
    #1;
    chk("bht_pred1", {31'd0, predict_taken}, 32'd1);
    tick();
    #1;
    chk("bht_pred2", {31'd0, predict_taken}, 32'd1);
    tick();
    // now saturated at 11: one not-taken must leave it at 10
    drive_br(32'h11C, 3'b000, 32'd5, 1'b0, 1'b0, 1'b0, 13'h10);
    #1;
    chk("bht_sat_pred", {31'd0, predict_taken}, 32'd1);
    tick();
    idle();
    #1;
    chk("bht_after_nt1", {31'd0, predict_taken}, 32'd1);
    drive_br(32'h11C, 3'b000, 32'd5, 1'b0, 1'b0, 1'b0, 13'h10);
    tick();
    idle();
    #1;
    chk("bht_after_nt2", {31'd0, predict_taken}, 32'd0);

    // Reset during an active flush with a trained entry
    drive_br(32'h11C, 3'b000, 32'd0, 1'b0, 1'b0, 1'b1, 13'h10);
    tick();
    idle();
    #1;
    chk("pre_rst_pred", {31'd0, predict_taken}, 32'd1);
    drive_jal(32'h108, 21'h20);
    tick();
    idle();
    rstB = 1'b0;
    #1;
    chk("rst_mid_flush_jmp", {31'd0, jmp_occur}, 32'd0);
    tick();
    rstB = 1'b1;
    #1;
    chk("post_rst_jmp", {31'd0, jmp_occur}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      chk("post_rst_pred", {31'd0, predict_taken}, 32'd0);
    end
    drive_jal(32'h108, 21'h20);
    #1;
    chk("post_rst_redirect", {31'd0, jmp_occur}, 32'd1);
    chk("post_rst_ret", pc_return, 32'h104);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
